bram_sdp_fifo_ctrl: RTL and testbench



---
 rtl/bram_sdp_fifo_pkg.sv | 13 +
 rtl/bram_sdp_fifo_ctrl_if.sv | 34 +++
 rtl/fifo_out_buf.sv | 64 ++++++
 rtl/bram_sdp_fifo_ctrl.sv | 84 ++++++++
 tb/tb_bram_sdp_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bram_sdp_fifo_pkg.sv
// rtl/bram_sdp_fifo_pkg.sv - shared constants and helpers for the BRAM SDP stream FIFO
package bram_sdp_fifo_pkg;

  localparam int BRAM_RD_LAT = 1;
  localparam int OUT_DEPTH   = 2;
  localparam int OCC_W       = $clog2(OUT_DEPTH + 1);

  // Room for the full BRAM plus the output buffer entries.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bram_sdp_fifo_ctrl_if.sv
// rtl/bram_sdp_fifo_ctrl_if.sv - stream and BRAM port bundle for the FIFO controller
interface bram_sdp_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
);
  import bram_sdp_fifo_pkg::*;

  localparam int CW = cnt_width(ADDR_WIDTH);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CW-1:0]         count;
  logic                  wce;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic                  rce;
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rq;

  modport slave (
    input  s_valid, s_data, m_ready, rq,
    output s_ready, m_valid, m_data, count, wce, wa, wd, rce, ra
  );

  modport master (
    output s_valid, s_data, m_ready, rq,
    input  s_ready, m_valid, m_data, count, wce, wa, wd, rce, ra
  );

endinterface

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - 2-entry first-word-fall-through register buffer behind the BRAM read port
module fifo_out_buf
  import bram_sdp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  // pop is pre-qualified with m_valid; push never arrives when both entries are held.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == '0) head_d = din;
        else             tail_d = din;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(1)) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign m_valid = (occ_q != '0);
  assign m_data  = head_q;
  assign occ     = occ_q;

endmodule

// File: rtl/bram_sdp_fifo_ctrl.sv
// rtl/bram_sdp_fifo_ctrl.sv - valid/ready FIFO controller driving a simple-dual-port BRAM
module bram_sdp_fifo_ctrl
  import bram_sdp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  bram_sdp_fifo_ctrl_if.slave bus
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]  rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]    mem_cnt_q, mem_cnt_d;
  logic [BRAM_RD_LAT-1:0] inflight_q, inflight_d;

  logic             s_ready;
  logic             push;
  logic             pop;
  logic             rce;
  logic             m_valid;
  logic [OCC_W-1:0] out_occ;
  logic [2:0]       occ_next;

  // s_ready only looks at registered state so there is no path from the pop side.
  assign s_ready  = rst_n & (mem_cnt_q != DEPTH);
  assign push     = bus.s_valid & s_ready;
  assign pop      = m_valid & bus.m_ready;
  assign occ_next = 3'(out_occ) + 3'(inflight_q[BRAM_RD_LAT-1]) - 3'(pop);
  assign rce      = (mem_cnt_q != '0) & (occ_next < 3'(OUT_DEPTH));

  always_comb begin
    wptr_d     = wptr_q + ADDR_WIDTH'(push);
    rptr_d     = rptr_q + ADDR_WIDTH'(rce);
    inflight_d = rce;
    mem_cnt_d  = mem_cnt_q;
    case ({push, rce})
      2'b10:   mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - (ADDR_WIDTH+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (inflight_q[BRAM_RD_LAT-1]),
    .din    (bus.rq),
    .pop    (pop),
    .m_valid(m_valid),
    .m_data (bus.m_data),
    .occ    (out_occ)
  );

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.wce     = push;
  assign bus.wa      = wptr_q;
  assign bus.wd      = {DATA_WIDTH{rst_n}} & bus.s_data;
  assign bus.rce     = rce;
  assign bus.ra      = rptr_q;
  assign bus.count   = CW'(mem_cnt_q) + CW'(inflight_q[BRAM_RD_LAT-1]) + CW'(out_occ);

endmodule

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// tb/tb_bram_sdp_fifo_ctrl.sv - directed self-checking bench for the BRAM SDP FIFO controller
module tb_bram_sdp_fifo_ctrl;

  localparam int AW  = 10;
  localparam int DW  = 36;
  localparam int BAW = 15;
  localparam int BDW = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n_push_a = 0;

  always #5 clk = ~clk;

  bram_sdp_fifo_ctrl_if #(.DATA_WIDTH(DW),  .ADDR_WIDTH(AW))  a_if ();
  bram_sdp_fifo_ctrl_if #(.DATA_WIDTH(BDW), .ADDR_WIDTH(BAW)) b_if ();

  bram_sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if)
  );

  bram_sdp_fifo_ctrl #(.DATA_WIDTH(BDW), .ADDR_WIDTH(BAW)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if)
  );

  // Behavioural SDP BRAMs with one cycle of read latency.
  logic [DW-1:0]  mem_a [0:(1<<AW)-1];
  logic [BDW-1:0] mem_b [0:(1<<BAW)-1];

  always @(posedge clk) begin
    if (a_if.wce) mem_a[a_if.wa] <= a_if.wd;
    if (a_if.rce) a_if.rq <= mem_a[a_if.ra];
    if (b_if.wce) mem_b[b_if.wa] <= b_if.wd;
    if (b_if.rce) b_if.rq <= mem_b[b_if.ra];
  end

  logic [DW-1:0] qa [$];
  logic          qb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fd(input int a);
    logic [DW-1:0] v;
    v = DW'(a);
    return v | (v << 20) | DW'(20'h55000);
  endfunction

  task automatic cyc_a(input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic [DW-1:0] exp;
    @(posedge clk);
    #1;
    a_if.s_valid = sv;
    a_if.s_data  = sd;
    a_if.m_ready = mr;
    #1;
    if (a_if.m_valid && mr) begin
      exp = (qa.size() != 0) ? qa.pop_front() : 'x;
      check("a_order", 64'(a_if.m_data), 64'(exp));
    end
    if (sv && a_if.s_ready) begin
      qa.push_back(sd);
      n_push_a++;
    end
  endtask

  task automatic cyc_b(input logic sv, input logic sd, input logic mr);
    logic exp;
    @(posedge clk);
    #1;
    b_if.s_valid = sv;
    b_if.s_data  = sd;
    b_if.m_ready = mr;
    #1;
    if (b_if.m_valid && mr) begin
      exp = (qb.size() != 0) ? qb.pop_front() : 1'bx;
      check("b_order", 64'(b_if.m_data), 64'(exp));
    end
    if (sv && b_if.s_ready) qb.push_back(sd);
  endtask

  initial begin
    int w;
    logic mr;
    a_if.s_valid = 1'b1;
    a_if.s_data  = 36'hF_FFFF_FFFF;
    a_if.m_ready = 1'b1;
    b_if.s_valid = 1'b0;
    b_if.s_data  = 1'b0;
    b_if.m_ready = 1'b0;

    // Reset state, with a push request held to prove the write port is gated.
    repeat (2) @(posedge clk);
    #2;
    check("rst_s_ready", 64'(a_if.s_ready), 64'd0);
    check("rst_m_valid", 64'(a_if.m_valid), 64'd0);
    check("rst_count",   64'(a_if.count),   64'd0);
    check("rst_wce",     64'(a_if.wce),     64'd0);
    check("rst_rce",     64'(a_if.rce),     64'd0);
    check("rst_wa",      64'(a_if.wa),      64'd0);
    check("rst_ra",      64'(a_if.ra),      64'd0);
    check("rst_wd",      64'(a_if.wd),      64'd0);
    check("rst_m_data",  64'(a_if.m_data),  64'd0);
    a_if.s_valid = 1'b0;
    a_if.m_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_s_ready", 64'(a_if.s_ready), 64'd1);

    // Empty latency: push at edge t, rce in t+1, m_valid in t+3.
    cyc_a(1'b1, 36'h0_5_5001, 1'b0);
    cyc_a(1'b0, '0, 1'b0);
    check("lat_rce_t1",    64'(a_if.rce),     64'd1);
    check("lat_mv_t1",     64'(a_if.m_valid), 64'd0);
    check("lat_count_t1",  64'(a_if.count),   64'd1);
    cyc_a(1'b0, '0, 1'b0);
    check("lat_rce_t2",    64'(a_if.rce),     64'd0);
    check("lat_mv_t2",     64'(a_if.m_valid), 64'd0);
    check("lat_count_t2",  64'(a_if.count),   64'd1);
    cyc_a(1'b0, '0, 1'b0);
    check("lat_mv_t3",     64'(a_if.m_valid), 64'd1);
    check("lat_mdata_t3",  64'(a_if.m_data),  64'h0_5_5001);
    check("lat_rce_t3",    64'(a_if.rce),     64'd0);
    cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);
    check("lat_count_end", 64'(a_if.count),   64'd0);
    check("lat_mv_end",    64'(a_if.m_valid), 64'd0);

    // Fill to 2**AW + 2 with the sink stalled, then drain in order.
    for (int a = 0; a < 1026; a++) begin
      cyc_a(1'b1, fd(a), 1'b0);
      check("fill_s_ready", 64'(a_if.s_ready), 64'd1);
    end
    cyc_a(1'b1, fd(1026), 1'b0);
    check("full_s_ready", 64'(a_if.s_ready), 64'd0);
    check("full_wce",     64'(a_if.wce),     64'd0);
    cyc_a(1'b0, '0, 1'b0);
    check("full_count",   64'(a_if.count),   64'd1026);
    for (int i = 0; i < 1100 && qa.size() != 0; i++) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);
    check("drain_left",   64'(qa.size()),    64'd0);
    check("drain_count",  64'(a_if.count),   64'd0);
    check("drain_mv",     64'(a_if.m_valid), 64'd0);

    // Streaming: one word per cycle, pointers wrap, occupancy settles at 3.
    for (int i = 0; i < 2200; i++) begin
      w = n_push_a;
      cyc_a(1'b1, DW'(36'h1_0000_0000 + i), 1'b1);
      check("strm_wa", 64'(a_if.wa), 64'(w % 1024));
      if (i >= 4) begin
        check("strm_mv",    64'(a_if.m_valid), 64'd1);
        check("strm_count", 64'(a_if.count),   64'd3);
        check("strm_ra",    64'(a_if.ra),      64'((w + 1023) % 1024));
      end
    end
    for (int i = 0; i < 20 && qa.size() != 0; i++) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);
    check("strm_left",  64'(qa.size()),  64'd0);
    check("strm_count_end", 64'(a_if.count), 64'd0);

    // Back-pressure: sink ready pattern 1,0,0,1 under continuous push.
    for (int i = 0; i < 200; i++) begin
      mr = (i % 4 == 0) || (i % 4 == 3);
      cyc_a(1'b1, DW'(36'h9_0000_0000 + i), mr);
      check("bp_occ_le2", 64'(dut_a.u_out.occ_q <= 2), 64'd1);
      if (dut_a.u_out.occ_q == 2 && !mr) check("bp_rce_sup", 64'(a_if.rce), 64'd0);
    end
    for (int i = 0; i < 300 && qa.size() != 0; i++) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);
    check("bp_left",  64'(qa.size()),  64'd0);
    check("bp_count", 64'(a_if.count), 64'd0);

    // Asynchronous reset mid-stream with 300 words held.
    for (int i = 0; i < 300; i++) cyc_a(1'b1, DW'(36'h7_0000_0000 + i), 1'b0);
    cyc_a(1'b0, '0, 1'b0);
    check("mid_count_pre", 64'(a_if.count), 64'd300);
    @(posedge clk);
    #1;
    a_if.s_valid = 1'b1;
    a_if.s_data  = 36'h7_FFFF_0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_m_valid", 64'(a_if.m_valid), 64'd0);
    check("mid_wce",     64'(a_if.wce),     64'd0);
    check("mid_rce",     64'(a_if.rce),     64'd0);
    check("mid_count",   64'(a_if.count),   64'd0);
    check("mid_s_ready", 64'(a_if.s_ready), 64'd0);
    rst_n = 1'b1;
    a_if.s_valid = 1'b0;
    qa.delete();
    n_push_a = 0;
    cyc_a(1'b1, 36'hABC, 1'b0);
    for (int i = 0; i < 10 && !a_if.m_valid; i++) cyc_a(1'b0, '0, 1'b0);
    check("mid_first_mv",   64'(a_if.m_valid), 64'd1);
    check("mid_first_word", 64'(a_if.m_data),  64'hABC);
    cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);
    check("mid_count_end",  64'(a_if.count),   64'd0);

    // Narrow 1-bit x 32768 configuration: fill completely, then drain.
    for (int i = 0; i < 32770; i++) cyc_b(1'b1, 1'(i % 2), 1'b0);
    cyc_b(1'b1, 1'b0, 1'b0);
    check("nar_s_ready", 64'(b_if.s_ready),       64'd0);
    check("nar_wce",     64'(b_if.wce),           64'd0);
    check("nar_mem_cnt", 64'(dut_b.mem_cnt_q),    64'd32768);
    cyc_b(1'b0, 1'b0, 1'b0);
    check("nar_count",   64'(b_if.count),         64'd32770);
    for (int i = 0; i < 32800 && qb.size() != 0; i++) cyc_b(1'b0, 1'b0, 1'b1);
    cyc_b(1'b0, 1'b0, 1'b0);
    check("nar_left",    64'(qb.size()),          64'd0);
    check("nar_count_end", 64'(b_if.count),       64'd0);
    check("nar_mv_end",  64'(b_if.m_valid),       64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
